// File: rtl/sfx_playback_scheduler_if.sv
// Control inputs and ROM-side outputs of the SFX playback scheduler.
// The master drives enable/mute/sfx_req; the scheduler (slave) drives the ROM fetch outputs.
interface sfx_playback_scheduler_if;
    logic        enable;
    logic        mute;
    logic [1:0]  sfx_req;
    logic [17:0] rom_addr;
    logic        rom_rden;
    logic [1:0]  src;
    logic        sfx_drop;
    logic        bgm_done;

    modport master (
        output enable, mute, sfx_req,
        input  rom_addr, rom_rden, src, sfx_drop, bgm_done
    );

    modport slave (
        input  enable, mute, sfx_req,
        output rom_addr, rom_rden, src, sfx_drop, bgm_done
    );
endinterface

// File: rtl/sfx_playback_scheduler.sv
// Schedules ROM sample fetches for background music and two sound effects, one per DAC_LR_CLK.
// Define BGM_LOOP_EN to loop the music; otherwise it stops at its last sample and flags bgm_done.
module sfx_playback_scheduler #(
    parameter int BGM_BASE  = 0,
    parameter int BGM_LEN   = 96378,
    parameter int SFX0_BASE = 96378,
    parameter int SFX0_LEN  = 4096,
    parameter int SFX1_BASE = 100474,
    parameter int SFX1_LEN  = 8192
) (
    input logic                     DAC_LR_CLK,
    input logic                     reset,
    sfx_playback_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BGM  = 2'd1,
        S_SFX0 = 2'd2,
        S_SFX1 = 2'd3
    } state_t;

    state_t      r_state;
    logic [16:0] r_bgm_pos;
    logic [16:0] r_sfx_pos;
    logic [17:0] r_rom_addr;
    logic        r_rom_rden;
    logic        r_sfx_drop;
    logic        r_bgm_done;

    logic        w_active;
    logic        w_bgm_at_end;
    logic [16:0] w_bgm_pos_nxt;
    logic [16:0] w_sfx_pos_inc;
    logic [17:0] w_bgm_addr;
    logic        w_take0;
    logic        w_take1;
    logic        w_drop;
    logic        w_sfx_end;
    logic        w_done_nxt;

    always_comb begin
        w_active     = (r_state != S_IDLE);
        w_bgm_at_end = (r_bgm_pos == 17'(BGM_LEN - 1));
        w_bgm_pos_nxt = r_bgm_pos;
        if (w_active) begin
`ifdef BGM_LOOP_EN
            w_bgm_pos_nxt = w_bgm_at_end ? '0 : r_bgm_pos + 17'd1;
`else
            w_bgm_pos_nxt = w_bgm_at_end ? r_bgm_pos : r_bgm_pos + 17'd1;
`endif
        end
`ifdef BGM_LOOP_EN
        w_done_nxt = 1'b0;
`else
        w_done_nxt = r_bgm_done || (w_active && w_bgm_at_end);
`endif
        w_sfx_pos_inc = r_sfx_pos + 17'd1;
        w_bgm_addr    = 18'(BGM_BASE) + {1'b0, w_bgm_pos_nxt};
        // SFX1 outranks SFX0; SFX0 can only start from BGM or restart itself.
        w_take1 = w_active && bus.sfx_req[1];
        w_take0 = (r_state == S_BGM || r_state == S_SFX0) && bus.sfx_req[0] && !bus.sfx_req[1];
        w_drop  = (bus.sfx_req[1] && !w_take1) || (bus.sfx_req[0] && !w_take0);
        w_sfx_end = (r_state == S_SFX0 && r_sfx_pos == 17'(SFX0_LEN - 1)) ||
                    (r_state == S_SFX1 && r_sfx_pos == 17'(SFX1_LEN - 1));
    end

    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_bgm_pos  <= '0;
            r_sfx_pos  <= '0;
            r_rom_addr <= '0;
            r_rom_rden <= 1'b0;
            r_sfx_drop <= 1'b0;
            r_bgm_done <= 1'b0;
        end else if (!bus.enable) begin
            r_state    <= S_IDLE;
            r_rom_rden <= 1'b0;
            r_sfx_drop <= |bus.sfx_req;
        end else begin
            r_sfx_drop <= w_drop;
            r_bgm_done <= w_done_nxt;
            r_bgm_pos  <= w_bgm_pos_nxt;
            if (w_take1) begin
                r_state    <= S_SFX1;
                r_sfx_pos  <= '0;
                r_rom_addr <= 18'(SFX1_BASE);
                r_rom_rden <= !bus.mute;
            end else if (w_take0) begin
                r_state    <= S_SFX0;
                r_sfx_pos  <= '0;
                r_rom_addr <= 18'(SFX0_BASE);
                r_rom_rden <= !bus.mute;
            end else begin
                case (r_state)
                    S_IDLE, S_BGM: begin
                        r_state    <= S_BGM;
                        r_rom_addr <= w_bgm_addr;
                        r_rom_rden <= !bus.mute && !w_done_nxt;
                    end
                    default: begin
                        if (w_sfx_end) begin
                            r_state    <= S_BGM;
                            r_rom_addr <= w_bgm_addr;
                            r_rom_rden <= !bus.mute && !w_done_nxt;
                        end else begin
                            r_sfx_pos  <= w_sfx_pos_inc;
                            r_rom_addr <= ((r_state == S_SFX1) ? 18'(SFX1_BASE) : 18'(SFX0_BASE))
                                          + {1'b0, w_sfx_pos_inc};
                            r_rom_rden <= !bus.mute;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_rden = r_rom_rden;
    assign bus.src      = r_state;
    assign bus.sfx_drop = r_sfx_drop;
    assign bus.bgm_done = r_bgm_done;

endmodule
